// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame keeper.
// Holds the FSM state encoding, the stop-slot index helper and a ceil-log2 helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Slot index of the stop bit: start, data bits, optional parity, stop.
  function automatic int unsigned stop_idx(int unsigned data_w, bit parity_en);
    return parity_en ? data_w + 2 : data_w + 1;
  endfunction

  function automatic int unsigned clog2(int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy counter and registered storage.
// Push is ignored when full unless a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned PtrW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int unsigned CntW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_keeper.sv
// Assembles UART frames from an external bit-slot index, checks them and buffers good ones.
// Define PARITY_CHECK_EN to add the parity slot and parity checking.
module uart_frame_keeper
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              rx,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overflow
);

`ifdef PARITY_CHECK_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LastDataIdx = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] ParityIdx   = IDX_W'(DATA_W + 1);
  localparam logic [IDX_W-1:0] StopIdx     = IDX_W'(stop_idx(DATA_W, ParityEn));

  uart_state_e       state_q, state_d;
  logic [IDX_W-1:0]  prev_idx_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overflow_q;
  logic              idx_event, parity_bad;
  logic              push_req, fifo_full, fifo_empty, pop;

  assign idx_event = (bit_idx != prev_idx_q);
  // Without the parity slot ParityEn is 0, so parity_bad and parity_err stay constant 0.
  assign parity_bad = ParityEn && (((^data_q) ^ par_q) != PARITY_ODD);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    par_d        = par_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push_req     = 1'b0;
    if (idx_event) begin
      if (bit_idx == '0) begin
        // Start slot from any state: a fresh frame aborts the current one silently.
        if (rx) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_IDLE;
          ST_DATA: begin
            if (bit_idx == prev_idx_q + 1'b1) begin
              for (int i = 0; i < int'(DATA_W); i++) begin
                if (bit_idx == IDX_W'(i + 1)) data_d[i] = rx;
              end
              if (bit_idx == LastDataIdx) state_d = ParityEn ? ST_PARITY : ST_STOP;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end
          ST_PARITY: begin
            if (bit_idx == ParityIdx) begin
              par_d   = rx;
              state_d = ST_STOP;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end
          ST_STOP: begin
            if (bit_idx == StopIdx) begin
              frame_err_d  = !rx;
              parity_err_d = parity_bad;
              push_req     = rx && !parity_bad;
            end else begin
              frame_err_d = 1'b1;
            end
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prev_idx_q   <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_idx_q   <= bit_idx;
      data_q       <= data_d;
      par_q        <= par_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign pop        = rd_ready && !fifo_empty;
  assign rd_valid   = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

  uart_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_req),
    .push_data(data_q),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .pop_data (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_keeper.sv
// Directed bench for uart_frame_keeper at DATA_W=8, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_frame_keeper;

`ifdef PARITY_CHECK_EN
  localparam logic [3:0] STOP = 4'd10;
`else
  localparam logic [3:0] STOP = 4'd9;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] bit_idx;
  logic       rx;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       parity_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_keeper #(
    .DATA_W    (8),
    .IDX_W     (4),
    .FIFO_DEPTH(4),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_idx   (bit_idx),
    .rx        (rx),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic drive_slot(input logic [3:0] idx, input logic r);
    @(negedge clk);
    bit_idx = idx;
    rx      = r;
  endtask

  // Leaves the stop slot driven; its event is taken at the next rising edge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_rx);
    drive_slot(4'd0, 1'b0);
    for (int i = 1; i <= 8; i++) drive_slot(4'(i), d[i-1]);
`ifdef PARITY_CHECK_EN
    drive_slot(4'd9, par);
`else
    if (par) rx = 1'b1;
`endif
    drive_slot(STOP, stop_rx);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic clear_counts();
    #1;
    fe_cnt = 0;
    pe_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    bit_idx  = STOP;
    rx       = 1'b1;
    rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    clear_counts();
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL good_valid_early got %b want 0", rd_valid); end
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL good_data got %h want a5", rd_data); end
    @(negedge clk);
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL good_data_hold got %h want a5", rd_data); end
    pop_one();
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL good_valid_after_pop got %b want 0", rd_valid); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL good_no_frame_err got %0d want 0", fe_cnt); end
  endtask

  task automatic test_bad_stop();
    clear_counts();
    send_frame(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL badstop_pulse got %b want 1", frame_err); end
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL badstop_pulse_end got %b want 0", frame_err); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL badstop_pulse_count got %0d want 1", fe_cnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL badstop_no_push got %b want 0", rd_valid); end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL parity_ok_valid got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'h07) begin errors++; $display("FAIL parity_ok_data got %h want 07", rd_data); end
    pop_one();
    send_frame(8'h07, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad_pulse got %b want 1", parity_err); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pe_cnt !== 1) begin errors++; $display("FAIL parity_bad_count got %0d want 1", pe_cnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL parity_bad_no_push got %b want 0", rd_valid); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL parity_no_frame_err got %0d want 0", fe_cnt); end
  endtask
`endif

  task automatic test_overflow();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(exp[i], ^exp[i], 1'b1);
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got %b want 0", overflow); end
    send_frame(8'h55, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid%0d got %b want 1", i, rd_valid); end
      checks++; if (rd_data !== exp[i]) begin errors++; $display("FAIL ovf_drain_data%0d got %h want %h", i, rd_data, exp[i]); end
      rd_ready = 1'b1;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", rd_valid); end
  endtask

  task automatic test_seq_jump();
    clear_counts();
    drive_slot(4'd0, 1'b0);
    drive_slot(4'd1, 1'b1);
    drive_slot(4'd2, 1'b0);
    drive_slot(4'd3, 1'b1);
    drive_slot(4'd6, 1'b1);
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL jump_pulse got %b want 1", frame_err); end
    send_frame(8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL jump_next_valid got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL jump_next_data got %h want 3c", rd_data); end
    pop_one();
    #1;
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL jump_pulse_count got %0d want 1", fe_cnt); end
  endtask

  task automatic test_restart();
    clear_counts();
    drive_slot(4'd0, 1'b0);
    drive_slot(4'd1, 1'b1);
    drive_slot(4'd2, 1'b1);
    drive_slot(4'd3, 1'b1);
    send_frame(8'h96, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (rd_data !== 8'h96) begin errors++; $display("FAIL restart_data got %h want 96", rd_data); end
    pop_one();
    #1;
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL restart_no_err got %0d want 0", fe_cnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL restart_single got %b want 0", rd_valid); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", overflow); end
    drive_slot(4'd0, 1'b0);
    drive_slot(4'd1, 1'b0);
    drive_slot(4'd2, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_data got %h want 00", rd_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got %b want 0", overflow); end
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL postreset_valid got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL postreset_data got %h want 5a", rd_data); end
    pop_one();
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL postreset_empty got %b want 0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_stop();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_overflow();
    test_seq_jump();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
